// File: rtl/fwd_pkg.sv
// fwd_pkg: forwarding select codes, per-stage destination metadata and the producer-match helper.
package fwd_pkg;
  localparam int RD_W = 8;
  localparam logic [1:0] FWD_SEL_RF     = 2'b00;
  localparam logic [1:0] FWD_SEL_EXMEM  = 2'b01;
  localparam logic [1:0] FWD_SEL_MEMWB  = 2'b10;
  localparam logic [1:0] FWD_SEL_WBHOLD = 2'b11;
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } stage_t;
  function automatic logic stage_hit(stage_t s, logic [RD_W-1:0] src, logic use_src);
    return use_src && s.valid && s.regwrite && (s.rd != '0) && (s.rd == src);
  endfunction
endpackage

// File: rtl/fwd_sel_ctrl_if.sv
// fwd_sel_ctrl_if: ID-stage hazard inputs and EX forwarding-select outputs of fwd_sel_ctrl.
interface fwd_sel_ctrl_if #(
  parameter int g_REG_ADDR_WIDTH = 5,
  parameter int g_CNT_WIDTH      = 16
);
  logic                        i_Id_Valid;
  logic [g_REG_ADDR_WIDTH-1:0] i_Id_Rs;
  logic [g_REG_ADDR_WIDTH-1:0] i_Id_Rt;
  logic                        i_Id_Use_Rs;
  logic                        i_Id_Use_Rt;
  logic [g_REG_ADDR_WIDTH-1:0] i_Id_Rd;
  logic                        i_Id_RegWrite;
  logic                        i_Id_MemRead;
  logic                        i_Flush;
  logic [1:0]                  o_FwdA_Sel;
  logic [1:0]                  o_FwdB_Sel;
  logic                        o_Stall;
  logic [g_CNT_WIDTH-1:0]      o_Stall_Count;
  modport slave (
    input  i_Id_Valid, i_Id_Rs, i_Id_Rt, i_Id_Use_Rs, i_Id_Use_Rt,
    input  i_Id_Rd, i_Id_RegWrite, i_Id_MemRead, i_Flush,
    output o_FwdA_Sel, o_FwdB_Sel, o_Stall, o_Stall_Count
  );
  modport master (
    output i_Id_Valid, i_Id_Rs, i_Id_Rt, i_Id_Use_Rs, i_Id_Use_Rt,
    output i_Id_Rd, i_Id_RegWrite, i_Id_MemRead, i_Flush,
    input  o_FwdA_Sel, o_FwdB_Sel, o_Stall, o_Stall_Count
  );
endinterface

// File: rtl/fwd_match.sv
// fwd_match: prioritized forwarding select and load-hazard flag for one source operand (MEM/WB level under FWD_WB_BYPASS_EN).
module fwd_match
  import fwd_pkg::*;
(
  input  logic [RD_W-1:0] src,
  input  logic            use_src,
  input  stage_t          idex,
  input  stage_t          exmem,
  input  stage_t          memwb,
  output logic [1:0]      sel,
  output logic            load_hz
);
`ifdef FWD_WB_BYPASS_EN
  localparam logic WB_EN = 1'b1;
`else
  localparam logic WB_EN = 1'b0;
`endif
  logic hit_ex, hit_mem, hit_wb, unused_bits;
  always_comb begin
    hit_ex      = stage_hit(idex, src, use_src);
    hit_mem     = stage_hit(exmem, src, use_src);
    hit_wb      = stage_hit(memwb, src, use_src) && WB_EN;
    sel         = hit_ex ? FWD_SEL_EXMEM : hit_mem ? FWD_SEL_MEMWB : hit_wb ? FWD_SEL_WBHOLD : FWD_SEL_RF;
    load_hz     = hit_ex && idex.memread;
    unused_bits = exmem.memread ^ memwb.memread;
  end
endmodule

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX operand-forwarding mux selects, load-use stall and stall counter; FWD_WB_BYPASS_EN enables the WB hold select.
module fwd_sel_ctrl
  import fwd_pkg::*;
#(
  parameter int g_REG_ADDR_WIDTH = 5,
  parameter int g_CNT_WIDTH      = 16
) (
  input logic           i_Clk,
  input logic           i_Rst_n,
  fwd_sel_ctrl_if.slave bus
);
  logic [g_REG_ADDR_WIDTH-1:0] rs, rt, rd;
  stage_t idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
  logic [1:0] sel_a, sel_b, sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [g_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic hz_a, hz_b, stall, bubble;
  assign rs = bus.i_Id_Rs;
  assign rt = bus.i_Id_Rt;
  assign rd = bus.i_Id_Rd;
  fwd_match u_match_a (
    .src(RD_W'(rs)), .use_src(bus.i_Id_Use_Rs), .idex(idex_q), .exmem(exmem_q),
    .memwb(memwb_q), .sel(sel_a), .load_hz(hz_a)
  );
  fwd_match u_match_b (
    .src(RD_W'(rt)), .use_src(bus.i_Id_Use_Rt), .idex(idex_q), .exmem(exmem_q),
    .memwb(memwb_q), .sel(sel_b), .load_hz(hz_b)
  );
  always_comb begin
    stall   = bus.i_Id_Valid && !bus.i_Flush && (hz_a || hz_b);
    bubble  = stall || bus.i_Flush || !bus.i_Id_Valid;
    idex_d  = bubble ? '0 : stage_t'{valid: 1'b1, rd: RD_W'(rd), regwrite: bus.i_Id_RegWrite, memread: bus.i_Id_MemRead};
    exmem_d = idex_q;
    memwb_d = exmem_q;
    sel_a_d = stall ? FWD_SEL_RF : sel_a;
    sel_b_d = stall ? FWD_SEL_RF : sel_b;
    cnt_d   = (stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      sel_a_q <= FWD_SEL_RF;
      sel_b_q <= FWD_SEL_RF;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.o_FwdA_Sel    = sel_a_q;
  assign bus.o_FwdB_Sel    = sel_b_q;
  assign bus.o_Stall       = stall;
  assign bus.o_Stall_Count = cnt_q;
endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// tb_fwd_sel_ctrl: directed and random ID streams checked against a distance-based model of in-flight producers.
module tb_fwd_sel_ctrl;
  logic i_Clk = 1'b0;
  logic i_Rst_n = 1'b0;
  fwd_sel_ctrl_if bus ();
  fwd_sel_ctrl dut (.i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .bus(bus));
  always #5 i_Clk = ~i_Clk;
`ifdef FWD_WB_BYPASS_EN
  localparam int MAX_DIST = 3;
`else
  localparam int MAX_DIST = 2;
`endif
  typedef struct {bit v; int rd; bit rw; bit mr;} ins_t;
  ins_t hist[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cnt_m = 0;
  bit last_stall;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit writes(ins_t p, int src, bit u);
    return u && p.v && p.rw && p.rd != 0 && p.rd == src;
  endfunction
  // select code equals the distance of the nearest in-flight producer
  function automatic int pick(int src, bit u, bit st);
    if (st) return 0;
    for (int d = 0; d < MAX_DIST; d++) if (writes(hist[d], src, u)) return d + 1;
    return 0;
  endfunction
  task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                      input int rd, input bit rw, input bit mr, input bit fl, input bit rn);
    int ea, eb;
    bit es;
    ins_t ni;
    @(negedge i_Clk);
    i_Rst_n = rn;
    bus.i_Id_Valid = v;
    bus.i_Id_Rs = 5'(rs);
    bus.i_Id_Rt = 5'(rt);
    bus.i_Id_Use_Rs = urs;
    bus.i_Id_Use_Rt = urt;
    bus.i_Id_Rd = 5'(rd);
    bus.i_Id_RegWrite = rw;
    bus.i_Id_MemRead = mr;
    bus.i_Flush = fl;
    #1;
    es = v && !fl && hist[0].mr && (writes(hist[0], rs, urs) || writes(hist[0], rt, urt));
    last_stall = bus.o_Stall;
    chk("stall", {31'd0, bus.o_Stall}, {31'd0, es});
    ea = pick(rs, urs, es);
    eb = pick(rt, urt, es);
    @(posedge i_Clk);
    #1;
    if (!rn) begin
      foreach (hist[k]) hist[k] = '{0, 0, 0, 0};
      ea = 0;
      eb = 0;
      cnt_m = 0;
    end else begin
      ni = '{v && !fl && !es, rd, rw, mr};
      hist.push_front(ni);
      void'(hist.pop_back());
      if (es && cnt_m < 65535) cnt_m++;
    end
    chk("sel_a", {30'd0, bus.o_FwdA_Sel}, ea);
    chk("sel_b", {30'd0, bus.o_FwdB_Sel}, eb);
    chk("count", {16'd0, bus.o_Stall_Count}, cnt_m);
  endtask
  task automatic op(input int rs, input int rt, input int rd, input bit mr);
    step(1, rs, rt, 1, 1, rd, 1, mr, 0, 1);
  endtask
  initial begin
    repeat (3) hist.push_back('{0, 0, 0, 0});
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_sel_a", {30'd0, bus.o_FwdA_Sel}, 0);
    chk("reset_count", {16'd0, bus.o_Stall_Count}, 0);
    op(1, 2, 3, 0);
    op(3, 4, 6, 0);
    chk("ex_ex_fwd", {30'd0, bus.o_FwdA_Sel}, 1);
    op(1, 2, 3, 0);
    op(1, 2, 7, 0);
    op(3, 4, 6, 0);
    chk("mem_ex_fwd", {30'd0, bus.o_FwdA_Sel}, 2);
    op(1, 2, 3, 0);
    op(1, 2, 3, 0);
    op(3, 4, 6, 0);
    chk("nearest_wins", {30'd0, bus.o_FwdA_Sel}, 1);
    op(1, 2, 5, 1);
    op(1, 5, 6, 0);
    chk("lu_stall", {31'd0, last_stall}, 1);
    chk("lu_bubble", {30'd0, bus.o_FwdB_Sel}, 0);
    op(1, 5, 6, 0);
    chk("lu_once", {31'd0, last_stall}, 0);
    chk("lu_fwd_b", {30'd0, bus.o_FwdB_Sel}, 2);
    chk("lu_count", {16'd0, bus.o_Stall_Count}, 1);
    op(1, 2, 0, 0);
    op(0, 0, 6, 0);
    chk("r0_no_fwd", {30'd0, bus.o_FwdA_Sel}, 0);
    op(1, 2, 3, 0);
    step(1, 3, 4, 0, 1, 6, 1, 0, 0, 1);
    chk("use_gate", {30'd0, bus.o_FwdA_Sel}, 0);
    op(1, 2, 5, 1);
    step(1, 1, 5, 1, 1, 6, 1, 0, 1, 1);
    chk("flush_no_stall", {31'd0, last_stall}, 0);
    op(1, 5, 6, 0);
    chk("flush_bubble", {30'd0, bus.o_FwdB_Sel}, 2);
    op(1, 2, 3, 0);
    step(1, 3, 3, 1, 1, 6, 1, 0, 0, 0);
    chk("rst_sel", {30'd0, bus.o_FwdA_Sel}, 0);
    chk("rst_count", {16'd0, bus.o_Stall_Count}, 0);
    op(3, 3, 6, 0);
    chk("rst_no_fwd", {30'd0, bus.o_FwdA_Sel}, 0);
    op(1, 2, 3, 0);
    op(1, 2, 7, 0);
    op(1, 2, 7, 0);
    op(3, 3, 6, 0);
    chk("dist3_a", {30'd0, bus.o_FwdA_Sel}, MAX_DIST == 3 ? 3 : 0);
    chk("dist3_b_same", {30'd0, bus.o_FwdB_Sel}, MAX_DIST == 3 ? 3 : 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 49) != 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
